// File: rtl/eeg_frame_assembler.sv
// Packs FEATURE_COUNT EEG samples into a frame, issues it to the detector, and holds it until the result returns.
// Optional HOLD watchdog is enabled by defining EEG_FRAME_TIMEOUT_EN.
module eeg_frame_assembler #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FEATURE_COUNT  = 178,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic                  downstream_ready,
    input  logic                  result_valid,
    output logic [DATA_WIDTH-1:0] frame_data [FEATURE_COUNT-1:0],
    output logic                  frame_valid,
    output logic [7:0]            frame_count,
    output logic                  timeout_flag
);

    localparam int unsigned     IDX_W    = $clog2(FEATURE_COUNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEATURE_COUNT - 1);

    typedef enum logic [1:0] {FILL, FULL, ISSUE, HOLD} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    if (FEATURE_COUNT < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("eeg_frame_assembler: FEATURE_COUNT must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

`ifdef EEG_FRAME_TIMEOUT_EN
    localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] hold_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    // Decoded from registered state only, so no input reaches it combinationally.
    assign sample_ready = (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            for (int unsigned i = 0; i < FEATURE_COUNT; i++) begin
                frame_data[i] <= '0;
            end
`ifdef EEG_FRAME_TIMEOUT_EN
            hold_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (sample_valid) begin
                        frame_data[idx] <= sample_in;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= FULL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Pulse and count are set on entry so they are visible during the ISSUE cycle itself.
                    if (downstream_ready) begin
                        state       <= ISSUE;
                        frame_valid <= 1'b1;
                        frame_count <= frame_count + 1'b1;
`ifdef EEG_FRAME_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    state <= HOLD;
                end
                HOLD: begin
`ifdef EEG_FRAME_TIMEOUT_EN
                    if (result_valid) begin
                        state    <= FILL;
                        hold_cnt <= '0;
                    end else if (hold_cnt == TO_LAST) begin
                        state        <= FILL;
                        hold_cnt     <= '0;
                        timeout_flag <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`else
                    if (result_valid) begin
                        state <= FILL;
                    end
`endif
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_eeg_frame_assembler.sv
// Randomized self-checking bench for eeg_frame_assembler against a queue-based frame model.
module tb_eeg_frame_assembler;

    localparam int DW = 16;
    localparam int FC = 178;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          downstream_ready = 1'b0;
    logic          result_valid = 1'b0;
    logic [DW-1:0] frame_data [FC-1:0];
    logic          frame_valid;
    logic [7:0]    frame_count;
    logic          timeout_flag;

    eeg_frame_assembler #(
        .DATA_WIDTH    (DW),
        .FEATURE_COUNT (FC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .downstream_ready(downstream_ready),
        .result_valid    (result_valid),
        .frame_data      (frame_data),
        .frame_valid     (frame_valid),
        .frame_count     (frame_count),
        .timeout_flag    (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: samples accepted into the current frame, and frames issued since reset.
    logic [DW-1:0] sent_q [$];
    int            exp_frames = 0;
    int            pulses;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pulses <= 0;
        else if (frame_valid) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_errs();
        int e = 0;
        for (int i = 0; i < FC; i++) begin
            if (i >= sent_q.size() || frame_data[i] !== sent_q[i]) e++;
        end
        return e;
    endfunction

    function automatic int nonzero_entries();
        int e = 0;
        for (int i = 0; i < FC; i++) begin
            if (frame_data[i] !== '0) e++;
        end
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous 16'h0100+i, mode 1: one idle cycle before each sample, mode 2: random gaps.
    task automatic fill(input int mode, input int n, output int cycles);
        int bad = 0;
        int gap;
        cycles = 0;
        sent_q.delete();
        for (int i = 0; i < n; i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                sample_valid = 1'b0;
                sample_in    = DW'($urandom);
                @(negedge clk);
                if (sample_ready !== 1'b1 || frame_valid !== 1'b0) bad++;
                cyc();
                cycles++;
            end
            sample_valid = 1'b1;
            sample_in    = (mode == 0) ? DW'(16'h0100 + i) : DW'($urandom);
            @(negedge clk);
            if (sample_ready !== 1'b1 || frame_valid !== 1'b0) bad++;
            sent_q.push_back(sample_in);
            cyc();
            cycles++;
        end
        sample_valid = (n == FC);
        sample_in    = 16'hDEAD;
        check("fill_ready", bad, 0);
    endtask

    // Entered one cycle after the last accept (FSM should be FULL).
    task automatic expect_issue(input int bp, input bit rv_in_issue, input int hold_extra);
        int bad = 0;
        for (int j = 0; j < bp; j++) begin
            downstream_ready = 1'b0;
            @(negedge clk);
            if (sample_ready !== 1'b0 || frame_valid !== 1'b0 || frame_errs() != 0) bad++;
            cyc();
        end
        if (bp > 0) check("backpressure", bad, 0);
        downstream_ready = 1'b1;
        @(negedge clk);
        check("full_ready", sample_ready, 0);
        check("full_no_pulse", frame_valid, 0);
        cyc();
        result_valid = rv_in_issue;
        exp_frames   = (exp_frames + 1) % 256;
        @(negedge clk);
        check("issue_pulse", frame_valid, 1);
        check("issue_count", frame_count, exp_frames);
        check("issue_timeout_clr", timeout_flag, 0);
        check("issue_ready", sample_ready, 0);
        check("frame_first", frame_data[0], sent_q[0]);
        check("frame_last", frame_data[FC-1], sent_q[FC-1]);
        check("frame_all", frame_errs(), 0);
        cyc();
        result_valid = 1'b0;
        @(negedge clk);
        check("single_pulse", frame_valid, 0);
        check("hold_ready", sample_ready, 0);
        check("pulse_total", pulses, exp_frames);
        cyc();
        bad = 0;
        for (int j = 0; j < hold_extra; j++) begin
            @(negedge clk);
            if (sample_ready !== 1'b0 || frame_errs() != 0) bad++;
            cyc();
        end
        if (hold_extra > 0) check("hold_frozen", bad, 0);
    endtask

    task automatic release_hold();
        sample_valid = 1'b0;
        result_valid = 1'b1;
        @(negedge clk);
        check("release_pre", sample_ready, 0);
        cyc();
        result_valid = 1'b0;
        @(negedge clk);
        check("refill_ready", sample_ready, 1);
        check("refill_data_kept", frame_errs(), 0);
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int bad;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", sample_ready, 1);
        check("rst_valid", frame_valid, 0);
        check("rst_count", frame_count, 0);
        check("rst_timeout", timeout_flag, 0);
        check("rst_data", nonzero_entries(), 0);
        rst_n = 1'b1;
        cyc();

        // Continuous fill, immediate issue
        downstream_ready = 1'b1;
        fill(0, FC, cycles);
        check("cont_cycles", cycles, FC);
        expect_issue(0, 1'b0, 3);
        release_hold();

        // Random gaps, 50-cycle backpressure starting the cycle FULL is entered, result_valid in ISSUE ignored
        downstream_ready = 1'b1;
        fill(2, FC, cycles);
        expect_issue(50, 1'b1, int'($urandom_range(1, 8)));
        release_hold();

        // Alternating valid
        fill(1, FC, cycles);
        check("gapped_cycles", cycles, 2 * FC);
        expect_issue(int'($urandom_range(0, 5)), 1'b0, 2);
        release_hold();

        // Reset after a partial frame
        fill(2, 90, cycles);
        rst_n = 1'b0;
        #2;
        check("midrst_ready", sample_ready, 1);
        check("midrst_valid", frame_valid, 0);
        check("midrst_count", frame_count, 0);
        check("midrst_data", nonzero_entries(), 0);
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        fill(0, FC, cycles);
        expect_issue(1, 1'b0, 0);

        // HOLD with result withheld (expect_issue leaves us on the second HOLD cycle)
        sample_valid = 1'b0;
        bad = 0;
`ifdef EEG_FRAME_TIMEOUT_EN
        for (int j = 0; j < TO - 2; j++) begin
            @(negedge clk);
            if (sample_ready !== 1'b0 || timeout_flag !== 1'b0) bad++;
            cyc();
        end
        check("to_hold", bad, 0);
        @(negedge clk);
        check("to_last_hold", sample_ready, 0);
        cyc();
        @(negedge clk);
        check("to_fill", sample_ready, 1);
        check("to_flag", timeout_flag, 1);
        cyc();
        fill(2, FC, cycles);
        @(negedge clk);
        check("to_flag_sticky", timeout_flag, 1);
        cyc();
        expect_issue(0, 1'b0, 0);
`else
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            if (sample_ready !== 1'b0 || timeout_flag !== 1'b0 || frame_errs() != 0) bad++;
            cyc();
        end
        check("hold_1000", bad, 0);
        release_hold();
        fill(2, FC, cycles);
        expect_issue(0, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
